// File: rtl/clk_divider_n.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider_n
//  Description : Programmable integer clock divider. Divides Clockin by a
//                run-time divisor N (2..2^WIDTH-1), producing Clockout and a
//                single-cycle Tick strobe at the start of each output period.
//                Divisor updates are staged and applied only at a period
//                boundary so Clockout never glitches.
//                Optional feature macro: CLKDIV_DUTY50_EN -- when defined, a
//                negedge helper flop gives exact 50% duty for odd N.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_divider_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             Clockin,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Clockout,
  output logic             Tick,
  output logic             Pending
);

  localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] c_default_cnt = WIDTH'(DEFAULT_DIV - 1);
  localparam logic [WIDTH-1:0] c_min_div     = WIDTH'(2);

  logic [WIDTH-1:0] r_div_q;   // active divisor
  logic [WIDTH-1:0] r_pend;    // staged divisor
  logic             r_pend_v;  // staged divisor is waiting
  logic [WIDTH-1:0] r_cnt;     // phase counter, 0..r_div_q-1
  logic             r_clk_p;   // posedge output flop
  logic             r_tick;

  logic [WIDTH-1:0] w_div_clamped;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH:0]   w_half;
  logic             w_wrap;
  logic [WIDTH-1:0] w_idle_div;

  // Ratios 0 and 1 cannot produce a clock, so they fold onto 2
  assign w_div_clamped = (Divisor < c_min_div) ? c_min_div : Divisor;
  assign w_cnt_inc     = r_cnt + WIDTH'(1);
  // One extra bit keeps ceil(N/2) exact at N = 2^WIDTH-1
  assign w_half        = ({1'b0, r_div_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
  assign w_wrap        = (r_cnt == (r_div_q - WIDTH'(1)));
  // While idle there is no period to protect, so a new ratio applies at once
  assign w_idle_div    = Load ? w_div_clamped : (r_pend_v ? r_pend : r_div_q);

  // Phase counter, divisor staging, tick strobe and posedge output flop
  always_ff @(posedge Clockin) begin
    if (Reset) begin
      r_div_q  <= c_default_div;
      r_pend   <= c_default_div;
      r_pend_v <= 1'b0;
      r_cnt    <= c_default_cnt;
      r_clk_p  <= 1'b0;
      r_tick   <= 1'b0;
    end else if (!Enable) begin
      // Park on the last phase so the first enabled edge starts a fresh period
      r_div_q  <= w_idle_div;
      r_cnt    <= w_idle_div - WIDTH'(1);
      r_pend_v <= 1'b0;
      r_clk_p  <= 1'b0;
      r_tick   <= 1'b0;
    end else if (w_wrap) begin
      r_cnt    <= '0;
      r_tick   <= 1'b1;
      r_clk_p  <= 1'b1;
      // A Load landing on the boundary itself goes straight to the active ratio
      if (Load) begin
        r_div_q <= w_div_clamped;
      end else if (r_pend_v) begin
        r_div_q <= r_pend;
      end
      r_pend_v <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_inc;
      r_tick  <= 1'b0;
      r_clk_p <= ({1'b0, w_cnt_inc} < w_half);
      if (Load) begin
        r_pend   <= w_div_clamped;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign Tick    = r_tick;
  assign Pending = r_pend_v;

`ifdef CLKDIV_DUTY50_EN
  logic r_clk_n;  // half-cycle delayed copy of r_clk_p

  // Negedge copy; ANDing with it trims half a cycle off the rising side
  always_ff @(negedge Clockin) begin
    if (Reset) begin
      r_clk_n <= 1'b0;
    end else begin
      r_clk_n <= r_clk_p;
    end
  end

  assign Clockout = r_div_q[0] ? (r_clk_p & r_clk_n) : r_clk_p;
`else
  assign Clockout = r_clk_p;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_divider_n
//  Description : Self-checking bench for clk_divider_n. A period-level model
//                (period length, position in period, staged ratio) predicts
//                Tick, Pending and Clockout at every half cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_divider_n;

  logic       Clockin = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       Load;
  logic [7:0] Divisor;
  logic       Clockout;
  logic       Tick;
  logic       Pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_n;        // current period length
  int m_pos;      // clock cycles since the current period started
  int m_staged;   // staged period length
  bit m_run;      // a period is in progress
  bit m_sv;       // staged value waiting
  bit m_tick;

  clk_divider_n #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
    .Clockin  (Clockin),
    .Reset    (Reset),
    .Enable   (Enable),
    .Load     (Load),
    .Divisor  (Divisor),
    .Clockout (Clockout),
    .Tick     (Tick),
    .Pending  (Pending)
  );

  always #5 Clockin = ~Clockin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Expected Clockout at half-cycle h of a period (h=0 is the wrap posedge)
  function automatic int exp_clk(input int h);
    if (!m_run) return 0;
    if (m_n % 2 == 0) return (h < m_n) ? 1 : 0;
`ifdef CLKDIV_DUTY50_EN
    return (h >= 1 && h <= m_n) ? 1 : 0;
`else
    return (h <= m_n) ? 1 : 0;
`endif
  endfunction

  // Advance the model by one Clockin posedge using the inputs present there
  task automatic model_edge();
    if (Reset) begin
      m_n = 5; m_run = 0; m_sv = 0; m_tick = 0; m_pos = 0;
    end else if (!Enable) begin
      if (Load) m_n = clamp(int'(Divisor));
      else if (m_sv) m_n = m_staged;
      m_sv = 0; m_run = 0; m_tick = 0; m_pos = 0;
    end else if (!m_run || m_pos == m_n - 1) begin
      if (Load) m_n = clamp(int'(Divisor));
      else if (m_sv) m_n = m_staged;
      m_sv = 0; m_pos = 0; m_run = 1; m_tick = 1;
    end else begin
      m_pos++;
      m_tick = 0;
      if (Load) begin
        m_staged = clamp(int'(Divisor));
        m_sv = 1;
      end
    end
  endtask

  // One full Clockin cycle: model update, then check after each edge
  task automatic cycle();
    @(posedge Clockin);
    model_edge();
    #1;
    check("tick", Tick, m_tick);
    check("pending", Pending, m_sv);
    check("clk_pos", Clockout, exp_clk(2 * m_pos));
    @(negedge Clockin);
    #1;
    check("clk_neg", Clockout, exp_clk(2 * m_pos + 1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Run until the model sits at position p of a running period
  task automatic wait_pos(input int p, input int limit);
    int k;
    k = 0;
    while (!(m_run && m_pos == p) && k < limit) begin
      cycle();
      k++;
    end
    if (k >= limit) check("wait_timeout", 1, 0);
  endtask

  task automatic load_once(input logic [7:0] d);
    Load = 1'b1; Divisor = d;
    cycle();
    Load = 1'b0;
  endtask

  initial begin
    m_n = 5; m_pos = 0; m_staged = 5; m_run = 0; m_sv = 0; m_tick = 0;
    Reset = 1'b1; Enable = 1'b0; Load = 1'b0; Divisor = '0;
    run(2);
    check("reset_pending", Pending, 0);
    check("reset_clk", Clockout, 0);

    // Default N=5 free-running
    Reset = 1'b0; Enable = 1'b1;
    run(12);

    // Load 4 mid-period: staged until the next wrap
    wait_pos(1, 20);
    load_once(8'd4);
    check("pending_after_load", Pending, 1);
    run(14);

    // Clamped divisors 0 and 1
    load_once(8'd0);
    run(8);
    load_once(8'd1);
    run(8);

    // Drop Enable while Clockout is high, then restart
    wait_pos(0, 10);
    Enable = 1'b0;
    run(4);
    Enable = 1'b1;
    cycle();
    check("restart_tick", Tick, 1);
    run(6);

    // Reset while a divisor is pending
    wait_pos(0, 10);
    load_once(8'd3);
    check("pending_before_reset", Pending, 1);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    check("reset_mid_clk", Clockout, 0);
    check("reset_mid_pending", Pending, 0);
    run(12);

    // Widest ratio
    load_once(8'd255);
    run(530);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      Reset   = ($urandom % 200) == 0;
      Enable  = ($urandom % 20) != 0;
      Load    = ($urandom % 15) == 0;
      Divisor = (($urandom % 10) == 0) ? 8'($urandom % 256) : 8'($urandom % 10);
      cycle();
    end
    Reset = 1'b0; Load = 1'b0; Enable = 1'b1;
    run(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
